icache_axi_rd_bridge: RTL and testbench

- Miss-service responder for the pipelined I-cache.
- Accepts the cache's level-held miss request (axi_ena/axi_pc), issues one single-beat AXI4 read on the AR channel, collects the R beat, and returns the 64-bit line half to the cache as a one-cycle axi_valid pulse with axi_inst.
- Sits between the I-cache and the AXI crossbar. Handles flush-while-outstanding by draining the AXI response and suppressing delivery.

---
 rtl/icache_axi_rd_bridge_pkg.sv | 19 +
 rtl/icache_axi_rd_bridge_if.sv | 35 +++
 rtl/icache_axi_rd_bridge.sv | 114 +++++++++++
 tb/tb_icache_axi_rd_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_axi_rd_bridge_pkg.sv
// Shared types and AXI constants for the I-cache miss-service read bridge.
package icache_axi_rd_bridge_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StAr,
    StR,
    StResp,
    StGap
  } state_e;

  localparam logic [1:0] BurstIncr = 2'b01;
  localparam logic [2:0] Size8B    = 3'b011;
  localparam logic [1:0] RespOkay  = 2'b00;
  localparam logic [7:0] LenSingle = 8'd0;

  localparam int unsigned RdIdDefault = 0;

endpackage

// File: rtl/icache_axi_rd_bridge_if.sv
// AXI4 read-address / read-data channel bundle used between the bridge and the crossbar.
interface icache_axi_rd_bridge_if
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4
);

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );

endinterface

// File: rtl/icache_axi_rd_bridge.sv
// Serves one I-cache miss at a time as a single-beat AXI4 read and returns the data as a pulse.
// A flush while the read is outstanding lets the beat drain but suppresses the return pulse.
module icache_axi_rd_bridge
  import icache_axi_rd_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned RD_ID  = RdIdDefault
) (
  input  logic              clk_i,
  input  logic              rst_ni,

  input  logic              axi_ena_i,
  input  logic [63:0]       axi_pc_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] axi_inst_o,
  output logic              axi_valid_o,
  output logic              axi_err_o,
  output logic [31:0]       miss_cnt_o,

  icache_axi_rd_bridge_if.master axi
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic [DATA_W-1:0] inst_q, inst_d;
  logic              err_q, err_d;
  logic [31:0]       cnt_q, cnt_d;
  logic              drop_q, drop_d;

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    inst_d   = inst_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    drop_d   = drop_q;

    unique case (state_q)
      StIdle: begin
        drop_d = 1'b0;
        if (axi_ena_i && !flush_i) begin
          araddr_d = {axi_pc_i[ADDR_W-1:3], 3'b000};
          state_d  = StAr;
        end
      end
      StAr: begin
        // arvalid must stay up until the handshake; a flush only marks the result for dropping.
        if (flush_i) begin
          drop_d = 1'b1;
        end
        if (axi.arready) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = StR;
        end
      end
      StR: begin
        if (axi.rvalid) begin
          inst_d = axi.rdata;
          err_d  = (axi.rresp != RespOkay);
          if (drop_q || flush_i) begin
            drop_d  = 1'b0;
            state_d = StIdle;
          end else begin
            state_d = StResp;
          end
        end else if (flush_i) begin
          drop_d = 1'b1;
        end
      end
      StResp: state_d = StGap;
      // Lets the cache write its tag and release axi_ena before we look at it again.
      StGap:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      araddr_q <= '0;
      inst_q   <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      inst_q   <= inst_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
    end
  end

  assign axi.arvalid = (state_q == StAr);
  assign axi.araddr  = araddr_q;
  assign axi.arid    = ID_W'(RD_ID);
  assign axi.arlen   = LenSingle;
  assign axi.arsize  = Size8B;
  assign axi.arburst = BurstIncr;
  assign axi.rready  = (state_q == StR);

  assign axi_valid_o = (state_q == StResp);
  assign axi_err_o   = (state_q == StResp) && err_q;
  assign axi_inst_o  = inst_q;
  assign miss_cnt_o  = cnt_q;

  // rlast is always 1 and rid is ignored with a single outstanding read.
  logic unused_in;
  assign unused_in = ^{axi_pc_i, axi.rlast, axi.rid};

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Self-checking bench: directed scenarios plus randomized cache/AXI traffic against a
// transaction-level model of the miss bridge.
module tb_icache_axi_rd_bridge;

  localparam int INF = 32'h7fff_ffff;

  logic        clk;
  logic        rst_n;
  logic        axi_ena;
  logic [63:0] axi_pc;
  logic        flush;
  logic [63:0] axi_inst;
  logic        axi_valid;
  logic        axi_err;
  logic [31:0] miss_cnt;

  icache_axi_rd_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) axi_bus ();

  icache_axi_rd_bridge #(
    .ADDR_W(32),
    .DATA_W(64),
    .ID_W  (4),
    .RD_ID (0)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .axi_ena_i  (axi_ena),
    .axi_pc_i   (axi_pc),
    .flush_i    (flush),
    .axi_inst_o (axi_inst),
    .axi_valid_o(axi_valid),
    .axi_err_o  (axi_err),
    .miss_cnt_o (miss_cnt),
    .axi        (axi_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: the miss currently being served and when a return pulse is due.
  logic        ar_open, r_open, flush_acc;
  logic [31:0] exp_addr;
  logic [63:0] exp_inst;
  logic        exp_err;
  int          pulse_at, idle_from, n_ar;

  // Stimulus knobs and bench-side AXI slave state.
  logic        rand_mode, b2b;
  logic        d_ena, d_flush;
  logic [63:0] d_pc, b2b_pc;
  int          ar_wait, r_wait_k, r_wait_cnt;
  logic [63:0] rdata_k;
  logic [1:0]  rresp_k;
  logic        s_r_pend;

  // Observations used by the hand-computed checks.
  int          pulse_cnt, last_pulse_cyc, arvalid_cycles, r_hs_cnt;
  logic [31:0] last_araddr;
  logic [63:0] last_inst;
  logic        last_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    ar_open   = 1'b0;
    r_open    = 1'b0;
    flush_acc = 1'b0;
    pulse_at  = -1;
    idle_from = cyc + 1;
    n_ar      = 0;
    s_r_pend  = 1'b0;
    axi_bus.arready = 1'b0;
    axi_bus.rvalid  = 1'b0;
  endtask

  task automatic step();
    logic hs_ar, hs_r;
    @(negedge clk);
    cyc++;
    chk("arvalid", axi_bus.arvalid, ar_open);
    chk("rready", axi_bus.rready, r_open);
    chk("axi_valid", axi_valid, cyc == pulse_at);
    chk("miss_cnt", miss_cnt, n_ar);
    if (cyc == pulse_at) begin
      chk("axi_inst", axi_inst, exp_inst);
      chk("axi_err", axi_err, exp_err);
    end else begin
      chk("axi_err_idle", axi_err, 1'b0);
    end
    if (axi_bus.arvalid) begin
      chk("araddr", axi_bus.araddr, exp_addr);
      chk("ar_const", {axi_bus.arid, axi_bus.arlen, axi_bus.arsize, axi_bus.arburst},
          {4'd0, 8'd0, 3'b011, 2'b01});
      last_araddr = axi_bus.araddr;
      arvalid_cycles++;
    end
    if (axi_valid) begin
      pulse_cnt++;
      last_pulse_cyc = cyc;
      last_inst = axi_inst;
      last_err = axi_err;
    end

    // Cache side.
    if (rand_mode) begin
      if (axi_valid) begin
        if ($urandom % 2 == 0) d_ena = 1'b0;
        else d_pc = {$urandom, $urandom};
      end else if (!d_ena) begin
        if ($urandom % 3 == 0) begin
          d_ena = 1'b1;
          d_pc  = {$urandom, $urandom};
        end
      end else if ($urandom % 10 == 0) begin
        d_pc = {$urandom, $urandom};
      end
      d_flush = ($urandom % 12 == 0);
      if (d_flush && ($urandom % 2 == 0)) d_ena = 1'b0;
    end else if (axi_valid) begin
      if (b2b) d_pc = b2b_pc;
      else d_ena = 1'b0;
    end
    axi_ena = d_ena;
    axi_pc  = d_pc;
    flush   = d_flush;

    // AXI slave side.
    if (rand_mode) begin
      axi_bus.arready = ($urandom % 3 != 0);
    end else begin
      axi_bus.arready = 1'b0;
      if (axi_bus.arvalid) begin
        if (ar_wait > 0) ar_wait--;
        else axi_bus.arready = 1'b1;
      end
    end
    hs_ar = axi_bus.arvalid && axi_bus.arready;
    axi_bus.rvalid = 1'b0;
    if (s_r_pend) begin
      if (r_wait_cnt > 0) r_wait_cnt--;
      else axi_bus.rvalid = 1'b1;
    end
    hs_r = axi_bus.rvalid && axi_bus.rready;

    // Model update for what the next cycle must show.
    if (ar_open || r_open) flush_acc = flush_acc | flush;
    if (hs_ar) begin
      ar_open  = 1'b0;
      r_open   = 1'b1;
      n_ar++;
      s_r_pend = 1'b1;
      axi_bus.rlast = 1'b1;
      if (rand_mode) begin
        r_wait_cnt    = $urandom_range(0, 3);
        axi_bus.rdata = {$urandom, $urandom};
        axi_bus.rresp = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
        axi_bus.rid   = 4'($urandom);
      end else begin
        r_wait_cnt    = r_wait_k;
        axi_bus.rdata = rdata_k;
        axi_bus.rresp = rresp_k;
        axi_bus.rid   = 4'd0;
      end
    end
    if (hs_r) begin
      s_r_pend = 1'b0;
      r_open   = 1'b0;
      r_hs_cnt++;
      if (flush_acc) begin
        idle_from = cyc + 1;
      end else begin
        pulse_at  = cyc + 1;
        exp_inst  = axi_bus.rdata;
        exp_err   = (axi_bus.rresp != 2'b00);
        idle_from = cyc + 3;
      end
    end
    if (!ar_open && !r_open && cyc >= idle_from && axi_ena && !flush) begin
      ar_open   = 1'b1;
      exp_addr  = {axi_pc[31:3], 3'b000};
      flush_acc = 1'b0;
      idle_from = INF;
    end
  endtask

  task automatic run_until_pulse(input int max_cyc);
    int p0, n;
    p0 = pulse_cnt;
    n  = 0;
    while (pulse_cnt == p0 && n < max_cyc) begin
      step();
      n++;
    end
    chk("pulse_seen", pulse_cnt != p0, 1'b1);
  endtask

  int start, p0, a0, h0, first_pulse;

  initial begin
    rst_n = 1'b0;
    rand_mode = 1'b0; b2b = 1'b0; b2b_pc = '0;
    d_ena = 1'b0; d_flush = 1'b0; d_pc = '0;
    axi_ena = 1'b0; flush = 1'b0; axi_pc = '0;
    ar_wait = 0; r_wait_k = 0; r_wait_cnt = 0; rdata_k = '0; rresp_k = '0;
    axi_bus.rdata = '0; axi_bus.rresp = '0; axi_bus.rlast = 1'b1; axi_bus.rid = '0;
    pulse_cnt = 0; last_pulse_cyc = 0; arvalid_cycles = 0; r_hs_cnt = 0;
    last_araddr = '0; last_inst = '0; last_err = 1'b0;
    exp_addr = '0; exp_inst = '0; exp_err = 1'b0;
    model_reset();

    repeat (3) @(negedge clk);
    chk("rst_arvalid", axi_bus.arvalid, 1'b0);
    chk("rst_rready", axi_bus.rready, 1'b0);
    chk("rst_valid_err", {axi_valid, axi_err}, 2'b00);
    chk("rst_inst", axi_inst, 64'h0);
    chk("rst_araddr", axi_bus.araddr, 32'h0);
    chk("rst_miss_cnt", miss_cnt, 32'h0);
    rst_n = 1'b1;
    model_reset();

    // Basic miss with rvalid two cycles after the AR handshake.
    d_ena = 1'b1; d_pc = 64'h0000_0000_8000_0014;
    ar_wait = 0; r_wait_k = 1; rdata_k = 64'h1122_3344_5566_7788; rresp_k = 2'b00;
    start = cyc + 1;
    run_until_pulse(20);
    chk("t1_araddr", last_araddr, 32'h8000_0010);
    chk("t1_inst", last_inst, 64'h1122_3344_5566_7788);
    chk("t1_err", last_err, 1'b0);
    chk("t1_miss_cnt", miss_cnt, 32'd1);
    chk("t1_latency", last_pulse_cyc - start, 4);
    repeat (3) step();

    // AR backpressure while the cache moves its pc.
    a0 = arvalid_cycles;
    d_ena = 1'b1; d_pc = 64'h0000_0000_8000_0040; ar_wait = 5; r_wait_k = 0;
    rdata_k = 64'h0bad_f00d_1234_5678;
    step();
    repeat (7) begin
      d_pc = {$urandom, $urandom};
      step();
    end
    run_until_pulse(10);
    chk("t2_arvalid_cycles", arvalid_cycles - a0, 6);
    chk("t2_araddr", last_araddr, 32'h8000_0040);
    chk("t2_miss_cnt", miss_cnt, 32'd2);
    repeat (3) step();

    // Flush one cycle after the AR handshake: beat drained, no pulse.
    p0 = pulse_cnt; h0 = r_hs_cnt;
    d_ena = 1'b1; d_pc = 64'h0000_0000_8000_0080; ar_wait = 0; r_wait_k = 3;
    step();
    step();
    d_flush = 1'b1; d_ena = 1'b0;
    step();
    d_flush = 1'b0;
    repeat (6) step();
    chk("t3_no_pulse", pulse_cnt - p0, 0);
    chk("t3_beat_drained", r_hs_cnt - h0, 1);
    chk("t3_rready_low", axi_bus.rready, 1'b0);
    chk("t3_miss_cnt", miss_cnt, 32'd3);

    // Error response, zero-wait AXI: minimum latency.
    d_ena = 1'b1; d_pc = 64'h0000_0000_8000_00cc; ar_wait = 0; r_wait_k = 0;
    rdata_k = 64'hdead_beef_cafe_f00d; rresp_k = 2'b10;
    start = cyc + 1;
    run_until_pulse(20);
    chk("t4_err", last_err, 1'b1);
    chk("t4_inst", last_inst, 64'hdead_beef_cafe_f00d);
    chk("t4_araddr", last_araddr, 32'h8000_00c8);
    chk("t4_latency", last_pulse_cyc - start, 3);
    rresp_k = 2'b00;
    repeat (3) step();

    // Asynchronous reset while arvalid is waiting for arready.
    d_ena = 1'b1; d_pc = 64'h0000_0000_8000_0200; ar_wait = 100;
    repeat (3) step();
    chk("t5_pre_arvalid", axi_bus.arvalid, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_arvalid_async", axi_bus.arvalid, 1'b0);
    chk("t5_miss_cnt_async", miss_cnt, 32'd0);
    chk("t5_araddr_async", axi_bus.araddr, 32'd0);
    d_ena = 1'b0; axi_ena = 1'b0; ar_wait = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Back-to-back misses with axi_ena held across the gap.
    b2b = 1'b1; b2b_pc = 64'h0000_0000_8000_0100;
    d_ena = 1'b1; d_pc = 64'h0000_0000_8000_0000; r_wait_k = 0;
    run_until_pulse(20);
    first_pulse = last_pulse_cyc;
    b2b = 1'b0;
    run_until_pulse(20);
    chk("t6_araddr", last_araddr, 32'h8000_0100);
    chk("t6_miss_cnt", miss_cnt, 32'd2);
    chk("t6_spacing", last_pulse_cyc - first_pulse, 5);
    repeat (3) step();

    // Randomized traffic, then drain.
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    d_ena = 1'b0; d_flush = 1'b0; ar_wait = 0; r_wait_k = 0;
    repeat (12) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
